mem_access_stage: RTL and testbench

- Memory-access (M) stage of the 5-stage pipeline. Sits between the execute/memory pipeline register and the memory/writeback pipeline register; its output bundle is that register's next-cycle input.
- Issues load/store requests on the data bus and holds each request until the response arrives.
- Aligns and extends load data, and flags misaligned accesses.
- Drives the M-stage stall request and the `dbus_not_busy` status used by flush gating downstream.

---
 rtl/mem_access_stage_pkg.sv | 39 +++
 rtl/mem_access_stage_load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline types for the memory-access stage: FSM states, access sizes, funct3 width codes.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // The low two funct3 bits encode log2 of the access width for both loads and stores.
    function automatic msize_t size_of(input logic [2:0] funct3);
        return msize_t'(funct3[1:0]);
    endfunction

    function automatic logic [7:0] byte_mask(input msize_t size);
        case (size)
            MSIZE_B: return 8'h01;
            MSIZE_H: return 8'h03;
            MSIZE_W: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: shift the raw bus word down to byte lane 0, then sign/zero extend per funct3.
module load_align
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_D:    data = shifted;
            F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU:   data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-bus request per aligned load/store and holds it until
// the response, passes non-memory results straight through, and flags misaligned accesses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_regwrite,
    input  logic            flush,
    input  logic            stall_in,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [REGW-1:0] out_rd,
    output logic            out_regwrite,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_misalign,
    output logic            stall_req,
    output logic            dbus_not_busy
);

    mem_state_t      state_q, state_d;
    msize_t          size_c, size_q;
    logic [2:0]      lsb_mask;
    logic [7:0]      strobe_c, strobe_q;
    logic [XLEN-1:0] sdata_c, data_q, addr_q, pc_q, result_q, load_data;
    logic [REGW-1:0] rd_q;
    logic [2:0]      funct3_q;
    logic            regwrite_q, is_load_q, kill_q;
    logic            mem_op, misalign, accept, capture, set_kill;
    logic            unused;

    // Address-accept handshake carries no information this stage needs.
    assign unused = dresp_addr_ok;

    assign mem_op   = in_is_load | in_is_store;
    assign size_c   = size_of(in_funct3);
    assign lsb_mask = 3'((4'd1 << size_c) - 4'd1);
    assign misalign = (in_addr[2:0] & lsb_mask) != 3'b000;
    assign strobe_c = in_is_store ? (byte_mask(size_c) << in_addr[2:0]) : 8'h00;
    assign sdata_c  = in_wdata << {in_addr[2:0], 3'b000};

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw    (dresp_data),
        .offset (addr_q[2:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and all stage outputs; everything reads as idle while reset is held.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        capture       = 1'b0;
        set_kill      = 1'b0;
        dreq_valid    = 1'b0;
        dreq_addr     = '0;
        dreq_size     = 3'b000;
        dreq_strobe   = 8'h00;
        dreq_data     = '0;
        out_valid     = 1'b0;
        out_pc        = '0;
        out_rd        = '0;
        out_regwrite  = 1'b0;
        out_wdata     = '0;
        out_misalign  = 1'b0;
        stall_req     = 1'b0;
        dbus_not_busy = 1'b1;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (in_valid && mem_op && misalign) begin
                        out_valid    = 1'b1;
                        out_misalign = 1'b1;
                        out_pc       = in_pc;
                        out_rd       = in_rd;
                    end else if (in_valid && mem_op) begin
                        accept    = 1'b1;
                        stall_req = 1'b1;
                        state_d   = REQ;
                    end else begin
                        out_valid    = in_valid;
                        out_pc       = in_pc;
                        out_rd       = in_rd;
                        out_regwrite = in_regwrite;
                        out_wdata    = in_result;
                    end
                end
                REQ: begin
                    dreq_valid    = 1'b1;
                    dreq_addr     = addr_q;
                    dreq_size     = {1'b0, size_q};
                    dreq_strobe   = strobe_q;
                    dreq_data     = data_q;
                    stall_req     = 1'b1;
                    dbus_not_busy = 1'b0;
                    set_kill      = flush;
                    // A killed transaction still runs to completion, then its result is dropped.
                    if (dresp_data_ok) begin
                        capture = !(kill_q || flush);
                        state_d = (kill_q || flush) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        out_valid    = 1'b1;
                        out_pc       = pc_q;
                        out_rd       = rd_q;
                        out_regwrite = regwrite_q;
                        out_wdata    = result_q;
                        state_d      = stall_in ? DONE : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Request and result latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= MSIZE_B;
            strobe_q   <= 8'h00;
            data_q     <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            funct3_q   <= 3'b000;
            is_load_q  <= 1'b0;
            kill_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                addr_q     <= in_addr;
                size_q     <= size_c;
                strobe_q   <= strobe_c;
                data_q     <= sdata_c;
                pc_q       <= in_pc;
                rd_q       <= in_rd;
                regwrite_q <= in_regwrite & in_is_load;
                funct3_q   <= in_funct3;
                is_load_q  <= in_is_load;
                kill_q     <= 1'b0;
            end else if (set_kill) begin
                kill_q <= 1'b1;
            end
            if (capture) result_q <= is_load_q ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model computes the expected stage
// outputs for every cycle of each instruction, and one negedge process compares them.
module tb_mem_access_stage;

    localparam int unsigned XLEN = 64;
    localparam int unsigned REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_is_load, in_is_store, in_regwrite, flush, stall_in;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr, in_wdata, in_result, in_pc;
    logic [REGW-1:0] in_rd;
    logic            dreq_valid, dresp_addr_ok, dresp_data_ok;
    logic [XLEN-1:0] dreq_addr, dreq_data, dresp_data;
    logic [2:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic            out_valid, out_regwrite, out_misalign, stall_req, dbus_not_busy;
    logic [XLEN-1:0] out_pc, out_wdata;
    logic [REGW-1:0] out_rd;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .in_pc(in_pc), .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush), .stall_in(stall_in),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .out_wdata(out_wdata), .out_misalign(out_misalign), .stall_req(stall_req),
        .dbus_not_busy(dbus_not_busy)
    );

    int checks = 0;
    int errors = 0;

    logic            chk_en = 1'b0;
    logic            e_valid, e_stall, e_dreq_valid, e_not_busy, e_misalign, e_regwrite;
    logic            care_out, care_wdata, care_req, care_ddata;
    logic [XLEN-1:0] e_pc, e_wdata, e_addr, e_ddata;
    logic [REGW-1:0] e_rd;
    logic [2:0]      e_size;
    logic [7:0]      e_strobe;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        cmp("out_valid", 64'(out_valid), 64'(e_valid));
        cmp("stall_req", 64'(stall_req), 64'(e_stall));
        cmp("dreq_valid", 64'(dreq_valid), 64'(e_dreq_valid));
        cmp("dbus_not_busy", 64'(dbus_not_busy), 64'(e_not_busy));
        cmp("out_misalign", 64'(out_misalign), 64'(e_misalign));
        if (care_out) begin
            cmp("out_pc", out_pc, e_pc);
            cmp("out_rd", 64'(out_rd), 64'(e_rd));
            cmp("out_regwrite", 64'(out_regwrite), 64'(e_regwrite));
            if (care_wdata) cmp("out_wdata", out_wdata, e_wdata);
        end
        if (care_req) begin
            cmp("dreq_addr", dreq_addr, e_addr);
            cmp("dreq_size", 64'(dreq_size), 64'(e_size));
            cmp("dreq_strobe", 64'(dreq_strobe), 64'(e_strobe));
            if (care_ddata) cmp("dreq_data", dreq_data, e_ddata);
        end
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    // Reference rules: access width, alignment, lane placement and load extension.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misalign(input logic [63:0] a, input logic [2:0] f3);
        return (a % 64'(nbytes(f3))) != 64'd0;
    endfunction

    function automatic logic [7:0] m_strobe(input logic [63:0] a, input logic [2:0] f3);
        int off = int'(a % 64'd8);
        return 8'(((1 << nbytes(f3)) - 1) << off);
    endfunction

    function automatic logic [63:0] m_sdata(input logic [63:0] a, input logic [63:0] wd);
        int off = int'(a % 64'd8);
        return wd << (off * 8);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [63:0] a,
                                           input logic [2:0] f3);
        int n = nbytes(f3);
        int off = int'(a % 64'd8);
        logic [63:0] v = raw >> (off * 8);
        logic [63:0] m;
        if (n == 8) return v;
        m = (64'd1 << (n * 8)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[n * 8 - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_valid = 1'b0; e_stall = 1'b0; e_dreq_valid = 1'b0; e_not_busy = 1'b1;
        e_misalign = 1'b0; e_regwrite = 1'b0;
        care_out = 1'b0; care_wdata = 1'b0; care_req = 1'b0; care_ddata = 1'b0;
        e_pc = '0; e_wdata = '0; e_addr = '0; e_ddata = '0; e_rd = '0; e_size = 3'b000;
        e_strobe = 8'h00;
    endtask

    task automatic exp_reset();
        exp_idle();
        care_out = 1'b1; care_wdata = 1'b1; care_req = 1'b1; care_ddata = 1'b1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 3'b000; in_addr = '0;
        in_wdata = '0; in_result = '0; in_pc = '0; in_rd = '0; in_regwrite = 0;
        flush = 0; stall_in = 0; dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
    endtask

    // flush_at: -1 none, 0 in the issue cycle, k>=1 in the k-th bus cycle, 100 in the first result cycle.
    task automatic run_op(input bit valid, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] res,
                          input logic [63:0] pc, input logic [4:0] rd, input bit rw,
                          input int nwait, input int flush_at, input int nstall,
                          input logic [63:0] rdata, input bit use_lit, input logic [63:0] lit);
        bit mem = valid && (ld || st);
        bit mis = mem && m_misalign(addr, f3);
        bit killed = (flush_at >= 1) && (flush_at <= nwait + 1);
        step();
        in_valid = valid; in_is_load = ld; in_is_store = st; in_funct3 = f3; in_addr = addr;
        in_wdata = wd; in_result = res; in_pc = pc; in_rd = rd; in_regwrite = rw;
        flush = (flush_at == 0); stall_in = 1'b0;
        dresp_addr_ok = 1'($urandom_range(0, 1));
        dresp_data_ok = 1'($urandom_range(0, 1));
        dresp_data = {$urandom, $urandom};
        exp_idle();
        if (flush_at == 0) begin
            return;
        end else if (!mem) begin
            e_valid = valid; care_out = valid; care_wdata = 1'b1;
            e_pc = pc; e_rd = rd; e_regwrite = rw; e_wdata = res;
            return;
        end else if (mis) begin
            e_valid = 1'b1; e_misalign = 1'b1; care_out = 1'b1; e_pc = pc; e_rd = rd;
            return;
        end
        e_stall = 1'b1;
        for (int k = 1; k <= nwait + 1; k++) begin
            step();
            flush = (flush_at == k);
            dresp_data_ok = (k == nwait + 1);
            dresp_data = (k == nwait + 1) ? rdata : {$urandom, $urandom};
            exp_idle();
            e_stall = 1'b1; e_dreq_valid = 1'b1; e_not_busy = 1'b0;
            care_req = 1'b1; care_ddata = st;
            e_addr = addr; e_size = {1'b0, f3[1:0]};
            e_strobe = st ? m_strobe(addr, f3) : 8'h00;
            e_ddata = m_sdata(addr, wd);
        end
        if (killed) begin
            step();
            flush = 1'b0; in_valid = 1'b0;
            dresp_data_ok = 1'($urandom_range(0, 1));
            exp_idle();
            return;
        end
        for (int d = 0; d <= nstall; d++) begin
            step();
            dresp_data_ok = 1'($urandom_range(0, 1));
            dresp_data = {$urandom, $urandom};
            exp_idle();
            if (flush_at == 100 && d == 0) begin
                flush = 1'b1; stall_in = 1'b0;
                return;
            end
            flush = 1'b0;
            stall_in = (d < nstall);
            e_valid = 1'b1; care_out = 1'b1; care_wdata = 1'b1;
            e_pc = pc; e_rd = rd; e_regwrite = ld & rw;
            e_wdata = use_lit ? lit : (ld ? m_load(rdata, addr, f3) : 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        exp_reset();
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        step();
        reset = 1'b0;
        exp_idle();

        // Pin the reference rules to hand-computed values.
        cmp("pin_lb", m_load(64'h0000_0000_8000_0000, 64'h8000_0003, 3'b000), 64'hFFFF_FFFF_FFFF_FF80);
        cmp("pin_lwu", m_load(64'hFEDC_BA98_7654_3210, 64'h4, 3'b110), 64'h0000_0000_FEDC_BA98);
        cmp("pin_lh", m_load(64'hFEDC_BA98_7654_3210, 64'h6, 3'b001), 64'hFFFF_FFFF_FFFF_FEDC);
        cmp("pin_sh_strobe", 64'(m_strobe(64'h1006, 3'b001)), 64'hC0);
        cmp("pin_sh_data", m_sdata(64'h1006, 64'hABCD), 64'hABCD_0000_0000_0000);
        cmp("pin_misalign", 64'(m_misalign(64'h1002, 3'b010)), 64'd1);

        // Directed cases.
        run_op(1, 0, 0, 3'b000, 64'h0, 64'h0, 64'h1234, 64'h100, 5'd5, 1, 0, -1, 0, 64'h0, 0, 64'h0);
        run_op(1, 1, 0, 3'b000, 64'h8000_0003, 64'h0, 64'h0, 64'h104, 5'd6, 1, 2, -1, 0,
               64'h0000_0000_8000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, 0, 1, 3'b001, 64'h1006, 64'hABCD, 64'h0, 64'h108, 5'd0, 0, 1, -1, 0, 64'h0, 0, 64'h0);
        run_op(1, 1, 0, 3'b010, 64'h1002, 64'h0, 64'h0, 64'h10C, 5'd7, 1, 0, -1, 0, 64'h0, 0, 64'h0);
        run_op(1, 1, 0, 3'b011, 64'h2000, 64'h0, 64'h0, 64'h110, 5'd8, 1, 3, 2, 0,
               64'h1111_2222_3333_4444, 0, 64'h0);
        run_op(1, 1, 0, 3'b010, 64'h2004, 64'h0, 64'h0, 64'h114, 5'd9, 1, 0, -1, 3,
               64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321);

        // Reset asserted while a request is outstanding.
        step();
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'b011; in_addr = 64'h3000;
        in_pc = 64'h118; in_rd = 5'd10; in_regwrite = 1; dresp_data_ok = 0;
        exp_idle(); e_stall = 1'b1;
        step();
        exp_idle(); e_stall = 1'b1; e_dreq_valid = 1'b1; e_not_busy = 1'b0;
        care_req = 1'b1; e_addr = 64'h3000; e_size = 3'd3;
        step();
        reset = 1'b1;
        exp_reset();
        #1;
        compare_all();
        step();
        clear_inputs();
        reset = 1'b0;
        exp_idle();

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            int kind = $urandom_range(0, 9);
            bit valid = (kind != 0);
            bit ld = (kind >= 1 && kind <= 4);
            bit st = (kind >= 5 && kind <= 7);
            logic [2:0] f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            logic [63:0] addr = {$urandom, $urandom};
            int fsel = $urandom_range(0, 19);
            int nwait = $urandom_range(0, 3);
            int fat = -1;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            if (fsel == 0) fat = 0;
            else if (fsel == 1) fat = $urandom_range(1, nwait + 1);
            else if (fsel == 2) fat = 100;
            run_op(valid, ld, st, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   nwait, fat, $urandom_range(0, 2), {$urandom, $urandom}, 0, 64'h0);
        end

        step();
        clear_inputs();
        exp_idle();
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
